// File: rtl/delay_line_scheduler_pkg.sv
// Shared types for the delay-line scheduler: sequencer states and tap-index sizing.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Width of the tap index; kept at least one bit so a single-tap build still has a counter.
  function automatic int tap_idx_w(input int ntaps);
    return (ntaps > 1) ? $clog2(ntaps) : 1;
  endfunction

endpackage

// File: rtl/delay_line_scheduler_if.sv
// Port bundle between the scheduler and the single-port delay-line RAM.
interface delay_line_scheduler_if #(
  parameter int BITSIZE = 24,
  parameter int ADDRLEN = 16
);
  logic [ADDRLEN-1:0] mem_addr;
  logic               mem_wren;
  logic [BITSIZE-1:0] mem_din;
  logic [BITSIZE-1:0] mem_dout;

  modport master (
    output mem_addr,
    output mem_wren,
    output mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_addr,
    input  mem_wren,
    input  mem_din,
    output mem_dout
  );
endinterface

// File: rtl/delay_line_scheduler.sv
// One write plus NTAPS delayed reads of a circular delay line per audio frame.
//   state | meaning
//   IDLE  | waiting for an lrclk rise with enable
//   WRITE | incoming sample being written at wr_ptr
//   READ  | read address for tap k on the bus
//   DRAIN | waiting for the last tap's read data
module delay_line_scheduler
  import delay_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int ADDRLEN = 16,
  parameter int NTAPS   = 2
) (
  input  logic                        bclk,
  input  logic                        reset,
  input  logic                        lrclk,
  input  logic                        enable,
  input  logic signed [BITSIZE-1:0]   sample_in,
  input  logic [NTAPS*ADDRLEN-1:0]    delay_cfg,
  delay_line_scheduler_if.master      mem,
  output logic [NTAPS*BITSIZE-1:0]    tap_out,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam int KW = tap_idx_w(NTAPS);
  localparam logic [KW-1:0] LAST_TAP = KW'(NTAPS - 1);

  state_t             state, state_nxt;
  logic [KW-1:0]      k, k_nxt, k_plus1;
  logic               lrclk_q;
  logic [ADDRLEN-1:0] wr_ptr;
  logic [ADDRLEN-1:0] dly_q [NTAPS];

  logic               start_req, start;
  logic [ADDRLEN-1:0] addr_nxt;
  logic               wren_nxt;
  logic [BITSIZE-1:0] din_nxt;
  logic               issue;
  logic [KW-1:0]      issue_k;

  // Read-data return pipeline: address registered, RAM samples, then capture.
  logic               pend1_v, pend2_v;
  logic [KW-1:0]      pend1_k, pend2_k;

  assign start_req = lrclk & ~lrclk_q & enable;
  assign start     = start_req & (state == IDLE);
  assign k_plus1   = k + 1'b1;

  always_ff @(posedge bclk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = READ;
        k_nxt     = '0;
      end
      READ: begin
        if (k == LAST_TAP) begin
          state_nxt = DRAIN;
        end else begin
          k_nxt = k_plus1;
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = mem.mem_addr;
    wren_nxt = 1'b0;
    din_nxt  = mem.mem_din;
    issue    = 1'b0;
    issue_k  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt = wr_ptr;
          wren_nxt = 1'b1;
          din_nxt  = sample_in;
        end
      end
      WRITE: begin
        addr_nxt = wr_ptr - dly_q[0];
        issue    = 1'b1;
      end
      READ: begin
        if (k != LAST_TAP) begin
          addr_nxt = wr_ptr - dly_q[k_plus1];
          issue    = 1'b1;
          issue_k  = k_plus1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      lrclk_q      <= 1'b0;
      wr_ptr       <= '0;
      mem.mem_addr <= '0;
      mem.mem_wren <= 1'b0;
      mem.mem_din  <= '0;
      tap_out      <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      pend1_v      <= 1'b0;
      pend2_v      <= 1'b0;
      pend1_k      <= '0;
      pend2_k      <= '0;
      for (int i = 0; i < NTAPS; i++) dly_q[i] <= '0;
    end else begin
      lrclk_q      <= lrclk;
      mem.mem_addr <= addr_nxt;
      mem.mem_wren <= wren_nxt;
      mem.mem_din  <= din_nxt;
      frame_done   <= 1'b0;
      pend1_v      <= issue;
      pend1_k      <= issue_k;
      pend2_v      <= pend1_v;
      pend2_k      <= pend1_k;

      if (start_req && state != IDLE) overrun <= 1'b1;

      if (start) begin
        for (int i = 0; i < NTAPS; i++) dly_q[i] <= delay_cfg[i*ADDRLEN +: ADDRLEN];
      end

      if (pend2_v) begin
        tap_out[pend2_k*BITSIZE +: BITSIZE] <= mem.mem_dout;
        // wr_ptr only advances once every tap of this frame has used it.
        if (pend2_k == LAST_TAP) begin
          wr_ptr     <= wr_ptr + 1'b1;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Directed bench for delay_line_scheduler with a behavioural single-port RAM.
module tb_delay_line_scheduler;
  localparam int BS = 24;
  localparam int AL = 4;
  localparam int NT = 2;

  logic           bclk;
  logic           reset;
  logic           lrclk;
  logic           enable;
  logic [BS-1:0]  sample_in;
  logic [NT*AL-1:0] delay_cfg;
  logic [NT*BS-1:0] tap_out;
  logic           frame_done;
  logic           overrun;

  delay_line_scheduler_if #(.BITSIZE(BS), .ADDRLEN(AL)) mem_bus ();

  delay_line_scheduler #(.BITSIZE(BS), .ADDRLEN(AL), .NTAPS(NT)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .enable    (enable),
    .sample_in (sample_in),
    .delay_cfg (delay_cfg),
    .mem       (mem_bus.master),
    .tap_out   (tap_out),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  logic [BS-1:0] ram [16];
  logic [BS-1:0] ref_mem [16];

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  always @(posedge bclk) begin
    if (mem_bus.mem_wren) ram[mem_bus.mem_addr] <= mem_bus.mem_din;
    mem_bus.mem_dout <= ram[mem_bus.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  logic [AL-1:0] wp = '0;
  logic [BS-1:0] last_t0 = '0, last_t1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  // Runs one full frame from E0 to E7 and checks bus activity, taps and frame_done.
  task automatic run_frame(input logic [BS-1:0] s, input logic [AL-1:0] d0, input logic [AL-1:0] d1,
                           input logic [BS-1:0] t0, input logic [BS-1:0] t1, input bit drop_en,
                           input string tag);
    logic [AL-1:0] a0, a1;
    a0 = wp - d0;
    a1 = wp - d1;
    sample_in = s;
    delay_cfg = {d1, d0};
    lrclk = 1'b1;
    step(); // E0
    chk($sformatf("%s_wr_en", tag), mem_bus.mem_wren, 1);
    chk($sformatf("%s_wr_addr", tag), mem_bus.mem_addr, wp);
    chk($sformatf("%s_wr_data", tag), mem_bus.mem_din, s);
    if (drop_en) enable = 1'b0;
    step(); // E1
    chk($sformatf("%s_rd0_addr", tag), mem_bus.mem_addr, a0);
    chk($sformatf("%s_rd0_wren", tag), mem_bus.mem_wren, 0);
    step(); // E2
    chk($sformatf("%s_rd1_addr", tag), mem_bus.mem_addr, a1);
    step(); // E3
    chk($sformatf("%s_tap0", tag), tap_out[BS-1:0], t0);
    chk($sformatf("%s_done_early", tag), frame_done, 0);
    step(); // E4
    chk($sformatf("%s_tap1", tag), tap_out[2*BS-1:BS], t1);
    chk($sformatf("%s_done", tag), frame_done, 1);
    lrclk = 1'b0;
    step(); // E5
    chk($sformatf("%s_done_once", tag), frame_done, 0);
    chk($sformatf("%s_wren_idle", tag), mem_bus.mem_wren, 0);
    step();
    step();
    wp = wp + 1'b1;
    last_t0 = t0;
    last_t1 = t1;
    enable = 1'b1;
  endtask

  typedef struct {
    logic [BS-1:0] s;
    logic [AL-1:0] d0;
    logic [AL-1:0] d1;
    logic [BS-1:0] t0;
    logic [BS-1:0] t1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cnt;
    logic [BS-1:0] e0, e1;
    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1; lrclk = 1'b0; enable = 1'b1; sample_in = '0; delay_cfg = '0;

    vecs[0] = '{s: 24'd10, d0: 4'd0, d1: 4'd3, t0: 24'd10, t1: 24'd0};
    vecs[1] = '{s: 24'd20, d0: 4'd0, d1: 4'd3, t0: 24'd20, t1: 24'd0};
    vecs[2] = '{s: 24'd30, d0: 4'd0, d1: 4'd3, t0: 24'd30, t1: 24'd0};
    vecs[3] = '{s: 24'd40, d0: 4'd0, d1: 4'd3, t0: 24'd40, t1: 24'd10};
    vecs[4] = '{s: 24'd50, d0: 4'd0, d1: 4'd3, t0: 24'd50, t1: 24'd20};

    // Reset values
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_din", mem_bus.mem_din, 0);
    chk("rst_tap", tap_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_bus.mem_wren) cnt++;
      step();
    end
    chk("rst_no_wren", cnt, 0);

    // Delay line, delays {0,3}
    for (int i = 0; i < 5; i++) begin
      ref_mem[wp] = vecs[i].s;
      run_frame(vecs[i].s, vecs[i].d0, vecs[i].d1, vecs[i].t0, vecs[i].t1, 1'b0, $sformatf("dl%0d", i));
    end

    // Wrap-around from a fresh write pointer
    reset = 1'b1; step(); reset = 1'b0; step();
    wp = '0;
    for (int i = 0; i < 17; i++) begin
      logic [AL-1:0] ai;
      ref_mem[wp] = BS'(200 + i);
      ai = wp - 4'd1;
      e0 = ref_mem[ai];
      e1 = ref_mem[wp];
      run_frame(BS'(200 + i), 4'd1, 4'd0, e0, e1, 1'b0, $sformatf("wrap%0d", i));
    end
    chk("wrap_last_tap0", last_t0, 24'd215);

    // Overrun: second rise two cycles after E0
    sample_in = 24'h55; delay_cfg = {4'd1, 4'd0}; lrclk = 1'b1;
    ref_mem[wp] = 24'h55;
    step(); // E0
    chk("ovr_wren", mem_bus.mem_wren, 1);
    chk("ovr_clear_at_start", overrun, 0);
    lrclk = 1'b0;
    step(); // E1
    lrclk = 1'b1;
    step(); // E2
    chk("ovr_set", overrun, 1);
    step(); // E3
    chk("ovr_tap0", tap_out[BS-1:0], 24'h55);
    step(); // E4
    e1 = ref_mem[wp - 4'd1];
    chk("ovr_done", frame_done, 1);
    chk("ovr_tap1", tap_out[2*BS-1:BS], e1);
    step(); // E5
    chk("ovr_done_once", frame_done, 0);
    chk("ovr_no_second_frame", mem_bus.mem_wren, 0);
    lrclk = 1'b0;
    last_t0 = 24'h55; last_t1 = e1;
    wp = wp + 1'b1;
    step(); step(); step();
    chk("ovr_sticky", overrun, 1);

    // Enable gating: rise with enable low does nothing
    enable = 1'b0; lrclk = 1'b1;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (mem_bus.mem_wren || frame_done) cnt++;
    end
    chk("en_off_no_access", cnt, 0);
    chk("en_off_tap0_hold", tap_out[BS-1:0], last_t0);
    chk("en_off_tap1_hold", tap_out[2*BS-1:BS], last_t1);
    lrclk = 1'b0; step(); step();
    enable = 1'b1;
    ref_mem[wp] = 24'h66;
    e1 = ref_mem[wp - 4'd2];
    run_frame(24'h66, 4'd0, 4'd2, 24'h66, e1, 1'b1, "en_drop");

    // Reset mid-frame at E2
    sample_in = 24'h77; delay_cfg = {4'd1, 4'd0}; lrclk = 1'b1;
    ref_mem[wp] = 24'h77;
    step(); // E0
    step(); // E1
    reset = 1'b1; lrclk = 1'b0;
    step(); // E2
    chk("mrst_tap", tap_out, 0);
    chk("mrst_addr", mem_bus.mem_addr, 0);
    chk("mrst_wren", mem_bus.mem_wren, 0);
    chk("mrst_overrun", overrun, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (frame_done) cnt++;
    end
    chk("mrst_no_done", cnt, 0);
    wp = '0;
    ref_mem[wp] = 24'h88;
    e1 = ref_mem[4'd15];
    run_frame(24'h88, 4'd0, 4'd1, 24'h88, e1, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_scheduler.md
# delay_line_scheduler

Sequences the shared single-port delay-line RAM (`memory`, BITSIZE × 2^ADDRLEN) for multi-tap delay effects. On every audio frame it performs one write of the incoming sample and NTAPS reads at programmable delays, then advances the circular write pointer. It sits between the I2S frame timing (bclk/lrclk) and the effect mixers, which consume the per-frame tap samples.

## Interface

**Parameters**
- `BITSIZE`, 24: sample width.
- `ADDRLEN`, 16: RAM address width; line depth is DEPTH = 2^ADDRLEN.
- `NTAPS`, 2: number of read taps per frame, 1..8.

**Ports**
- `bclk` in 1: the only clock. All logic is on posedge.
- `reset` in 1: synchronous, active-high.
- `lrclk` in 1: frame clock, sampled on bclk.
- `enable` in 1: permits new frames to start.
- `sample_in` in BITSIZE (signed): sample to store; latched at frame start.
- `delay_cfg` in NTAPS×ADDRLEN: tap i delay in samples, in bits [i*ADDRLEN +: ADDRLEN]; latched at frame start.
- `mem_addr` out ADDRLEN: RAM address (registered).
- `mem_wren` out 1: RAM write enable (registered).
- `mem_din` out BITSIZE: RAM write data (registered).
- `mem_dout` in BITSIZE: RAM read data, valid 1 cycle after the address is sampled.
- `tap_out` out NTAPS×BITSIZE: latest tap samples; tap i occupies [i*BITSIZE +: BITSIZE].
- `frame_done` out 1: one-cycle pulse when all taps of the frame are updated.
- `overrun` out 1: sticky flag; cleared only by reset.

## Operation

- **Frame start:** at a bclk edge where lrclk=1, the registered previous lrclk=0, enable=1, and state=IDLE.
- **States:**
  - IDLE → WRITE on frame start.
  - WRITE → READ (tap index k=0).
  - READ stays in READ while k<NTAPS-1 (k++). On k=NTAPS-1 it goes to DRAIN.
  - DRAIN → IDLE.
- **At frame start:**
  - latch sample_in and delay_cfg;
  - drive mem_addr=wr_ptr, mem_wren=1, mem_din=sample.
- **In READ k:** drive mem_addr = (wr_ptr − delay[k]) mod DEPTH and mem_wren=0.
- **Capture:** mem_dout is captured into tap_out[k] exactly one cycle after READ k's address is sampled.
- **Frame end:** on the final capture, set wr_ptr = wr_ptr+1 mod DEPTH and pulse frame_done.
- **Delay arithmetic:** unsigned ADDRLEN-bit subtraction with natural wrap.
  - Delay 0 returns the sample just written this frame.
  - Delay D returns the sample written D frames earlier.
- **Overrun:** a frame-start condition (lrclk rise with enable=1) while state≠IDLE is ignored and sets overrun.
- **enable:** deasserting enable mid-frame does not abort; the frame completes. With enable=0, no RAM accesses occur and tap_out holds its value.
- **Reset:** reset mid-frame aborts immediately and restores all reset values. RAM contents are untouched.
- **Reset values:**
  - state IDLE, wr_ptr 0;
  - mem_addr 0, mem_wren 0, mem_din 0;
  - tap_out all 0, frame_done 0, overrun 0;
  - registered lrclk 0.

## Timing

- E0 = edge that detects frame start. Outputs update after each edge.
- After E0: WRITE cycle; mem_wren=1, address wr_ptr. The RAM writes at E1.
- After E1+k (k=0..NTAPS-1): read address for tap k, mem_wren=0.
- At E3+k: tap_out[k] updates.
- After E(2+NTAPS): frame_done=1 for exactly one cycle; wr_ptr has incremented.
- Frame latency from E0 to frame_done is 2+NTAPS cycles; for NTAPS=2 it is 4.
- The block must be IDLE by E(3+NTAPS). The minimum lrclk period is NTAPS+4 bclk cycles; normal I2S is 64.
- mem_wren is high for exactly one cycle per frame.

## Structure

- **Shared package `delay_pkg`:**
  - state enum (IDLE, WRITE, READ, DRAIN);
  - tap-index width localparam $clog2(NTAPS).
- **Instances:** no sub-module. The RAM (`memory`) is instantiated by the parent and connected through the mem_* ports.
- **Edge detection:** the lrclk edge detector is inline (one flop).

## Test plan

- **Reset values:** assert reset for 3 cycles, then drive lrclk idle → all outputs 0 and no mem_wren activity.
- **Delay line:** NTAPS=2, delay_cfg={0,3}; feed samples 10, 20, 30, 40, 50 on successive frames.
  - At frame 5: tap0=50 and tap1=20.
  - tap1=0 for frames 1–3 on zero-initialised RAM.
  - frame_done pulses once per frame, 4 cycles after E0.
- **Wrap-around:** ADDRLEN=4; run 17 frames with delay 1 → mem_addr cycles 0..15, 0; tap correct across the 15 → 0 boundary; read address for wr_ptr=0, delay=1 is 15.
- **Overrun:** second lrclk rise 2 cycles after E0 → ignored, overrun=1 stays set, the current frame completes normally; only reset clears it.
- **Reset mid-frame:** reset at E2 → wr_ptr=0, tap_out=0, frame_done never pulses; the next frame writes address 0.
- **Enable gating:** enable=0 at a lrclk rise → no RAM access and tap_out unchanged; enable dropped at E1 → the frame completes and frame_done pulses.
